// File: rtl/pwm_deadtime.sv
// Dead-time insertion stage: turns raw per-channel PWM into complementary
// high/low gate drive pairs with a programmable gap and a sticky break latch.
module pwm_deadtime #(
    parameter int CH_NUM   = 4,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [DT_WIDTH-1:0] dt_i,
    input  logic [CH_NUM-1:0]   pwm_i,
    input  logic                brk_i,
    input  logic                brk_clr_i,
    output logic [CH_NUM-1:0]   pwm_h_o,
    output logic [CH_NUM-1:0]   pwm_l_o,
    output logic                brk_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DT_H = 3'd1,
        ST_HIGH = 3'd2,
        ST_DT_L = 3'd3,
        ST_LOW  = 3'd4
    } state_e;

    // Per-channel state and dead-time counter; state_q is the observable
    // FSM state for any bound checker.
    state_e              state_q [CH_NUM];
    state_e              state_d [CH_NUM];
    logic [DT_WIDTH-1:0] cnt_q   [CH_NUM];
    logic [DT_WIDTH-1:0] cnt_d   [CH_NUM];

    logic [CH_NUM-1:0]   pwm_q;
    logic [CH_NUM-1:0]   pwm_d;
    logic                brk_q;
    logic                brk_d;

    logic                hold;
    logic                dt_zero;
    logic [DT_WIDTH-1:0] dt_load;

    // Any break source or disable parks every channel in IDLE.
    assign hold    = brk_i | brk_q | ~en_i;
    assign dt_zero = (dt_i == '0);
    assign dt_load = dt_i - DT_WIDTH'(1);
    assign pwm_d   = pwm_i;

    // Set has priority over clear so a clear coinciding with a live fault is ignored.
    always_comb begin
        brk_d = brk_q;
        if (brk_i) begin
            brk_d = 1'b1;
        end else if (brk_clr_i) begin
            brk_d = 1'b0;
        end
    end

    always_comb begin
        for (int n = 0; n < CH_NUM; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            if (hold) begin
                state_d[n] = ST_IDLE;
                cnt_d[n]   = '0;
            end else begin
                case (state_q[n])
                    ST_IDLE: begin
                        if (pwm_q[n]) begin
                            state_d[n] = dt_zero ? ST_HIGH : ST_DT_H;
                        end else begin
                            state_d[n] = dt_zero ? ST_LOW : ST_DT_L;
                        end
                        cnt_d[n] = dt_zero ? '0 : dt_load;
                    end
                    ST_LOW: begin
                        if (pwm_q[n]) begin
                            state_d[n] = dt_zero ? ST_HIGH : ST_DT_H;
                            cnt_d[n]   = dt_zero ? '0 : dt_load;
                        end
                    end
                    ST_HIGH: begin
                        if (!pwm_q[n]) begin
                            state_d[n] = dt_zero ? ST_LOW : ST_DT_L;
                            cnt_d[n]   = dt_zero ? '0 : dt_load;
                        end
                    end
                    ST_DT_H: begin
                        // A gap shorter than the dead time returns to LOW without ever driving high.
                        if (!pwm_q[n]) begin
                            state_d[n] = ST_LOW;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == '0) begin
                            state_d[n] = ST_HIGH;
                        end else begin
                            cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
                        end
                    end
                    ST_DT_L: begin
                        if (pwm_q[n]) begin
                            state_d[n] = ST_HIGH;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == '0) begin
                            state_d[n] = ST_LOW;
                        end else begin
                            cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[n] = ST_IDLE;
                        cnt_d[n]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pwm_q <= '0;
            brk_q <= 1'b0;
            for (int n = 0; n < CH_NUM; n++) begin
                state_q[n] <= ST_IDLE;
                cnt_q[n]   <= '0;
            end
        end else begin
            pwm_q <= pwm_d;
            brk_q <= brk_d;
            for (int n = 0; n < CH_NUM; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // A live fault kills the drive in the same cycle, ahead of the FSM reaching IDLE.
    always_comb begin
        pwm_h_o = '0;
        pwm_l_o = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            pwm_h_o[n] = (state_q[n] == ST_HIGH) & ~brk_i;
            pwm_l_o[n] = (state_q[n] == ST_LOW) & ~brk_i;
        end
    end

    assign brk_o = brk_q;

endmodule
